// File: rtl/ffs_rr_arbiter.sv
// Round-robin arbiter with MSB-first numbering: requester k sits on
// i_req[N_CANDIDATES-1-k]. A rotating search pointer picks the winner,
// and a grant lasts until release, request drop, or MAX_HOLD cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; arbitrate on any request at the next edge
// S_GRANT | owner holds the resource; watch release/drop/hold limit
module ffs_rr_arbiter #(
   parameter int N_CANDIDATES = 8,
   parameter int MAX_HOLD     = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [N_CANDIDATES-1:0]         i_req,
   input  logic                            i_release,
   output logic                            o_grant_valid,
   output logic [$clog2(N_CANDIDATES)-1:0] o_grant_idx,
   output logic [N_CANDIDATES-1:0]         o_grant_onehot,
   output logic                            o_timeout
);

   localparam int IDX_W  = $clog2(N_CANDIDATES);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   if ((N_CANDIDATES < 2) || ((N_CANDIDATES & (N_CANDIDATES - 1)) != 0)) begin : g_bad_n
      $fatal(1, "ffs_rr_arbiter: N_CANDIDATES must be a power of 2 and at least 2");
   end
   if (MAX_HOLD < 1) begin : g_bad_hold
      $fatal(1, "ffs_rr_arbiter: MAX_HOLD must be at least 1");
   end

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic                    valid_q, valid_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [N_CANDIDATES-1:0] onehot_q, onehot_d;
   logic                    timeout_q, timeout_d;

   // Requests re-indexed so that bit k belongs to requester k.
   logic [N_CANDIDATES-1:0] req_idx;
   logic [IDX_W-1:0]        win_idx;
   logic                    any_req;
   logic [N_CANDIDATES-1:0] win_onehot;

   // Reorder the request vector into index order.
   always_comb begin
      req_idx = '0;
      for (int k = 0; k < N_CANDIDATES; k++) begin
         req_idx[k] = i_req[N_CANDIDATES-1-k];
      end
   end

   // First-set search starting at the pointer, wrapping at IDX_W bits.
   always_comb begin
      logic [IDX_W-1:0] cand;
      win_idx = '0;
      any_req = 1'b0;
      cand    = '0;
      for (int i = 0; i < N_CANDIDATES; i++) begin
         cand = ptr_q + IDX_W'(i);
         if (!any_req && req_idx[cand]) begin
            any_req = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Decode the winner back into i_req bit positions.
   always_comb begin
      win_onehot = '0;
      for (int k = 0; k < N_CANDIDATES; k++) begin
         win_onehot[N_CANDIDATES-1-k] = (win_idx == IDX_W'(k));
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         onehot_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         onehot_q  <= onehot_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic; release/drop outranks the hold limit.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      onehot_d  = onehot_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d  = S_GRANT;
               valid_d  = 1'b1;
               idx_d    = win_idx;
               onehot_d = win_onehot;
               ptr_d    = win_idx + IDX_W'(1);
               hold_d   = HOLD_W'(1);
            end else begin
               valid_d  = 1'b0;
               idx_d    = '0;
               onehot_d = '0;
               hold_d   = '0;
            end
         end
         S_GRANT: begin
            if (i_release || !req_idx[idx_q]) begin
               state_d  = S_IDLE;
               valid_d  = 1'b0;
               idx_d    = '0;
               onehot_d = '0;
               hold_d   = '0;
            end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
               state_d   = S_IDLE;
               valid_d   = 1'b0;
               idx_d     = '0;
               onehot_d  = '0;
               hold_d    = '0;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            idx_d    = '0;
            onehot_d = '0;
            hold_d   = '0;
         end
      endcase
   end

   // Outputs come straight from registers.
   always_comb begin
      o_grant_valid  = valid_q;
      o_grant_idx    = idx_q;
      o_grant_onehot = onehot_q;
      o_timeout      = timeout_q;
   end

endmodule

// File: tb/tb_ffs_rr_arbiter.sv
// Directed bench for ffs_rr_arbiter with N_CANDIDATES=8, MAX_HOLD=4.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_ffs_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       rel;
   logic       gv;
   logic [2:0] gidx;
   logic [7:0] goh;
   logic       gto;

   int checks = 0;
   int errors = 0;

   ffs_rr_arbiter #(.N_CANDIDATES(8), .MAX_HOLD(4)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req          (req),
      .i_release      (rel),
      .o_grant_valid  (gv),
      .o_grant_idx    (gidx),
      .o_grant_onehot (goh),
      .o_timeout      (gto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                          input logic [7:0] oh, input logic to);
      chk({tag, ".valid"},   32'(gv),   32'(v));
      chk({tag, ".idx"},     32'(gidx), 32'(idx));
      chk({tag, ".onehot"},  32'(goh),  32'(oh));
      chk({tag, ".timeout"}, 32'(gto),  32'(to));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = 8'hFF;
      rel = 1'b0;

      // Reset held with all requests up: nothing granted.
      repeat (2) @(posedge clk);
      #1;
      chk_all("in_reset", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_all("first_grant", 1'b1, 3'd0, 8'b1000_0000, 1'b0);   // ptr -> 1

      // Owner drops its request.
      req = 8'h00;
      tick();
      chk_all("drop_after_reset", 1'b0, 3'd0, 8'h00, 1'b0);

      // Round robin between idx 2 and idx 5.
      req = 8'b0010_0100;
      tick();
      chk_all("rr_g1", 1'b1, 3'd2, 8'b0010_0000, 1'b0);       // ptr -> 3
      rel = 1'b1;
      tick();
      chk_all("rr_gap1", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;
      tick();
      chk_all("rr_g2", 1'b1, 3'd5, 8'b0000_0100, 1'b0);       // ptr -> 6
      rel = 1'b1;
      tick();
      chk_all("rr_gap2", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;
      tick();
      chk_all("rr_g3", 1'b1, 3'd2, 8'b0010_0000, 1'b0);       // ptr -> 3
      rel = 1'b1;
      tick();
      chk_all("rr_gap3", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;
      req = 8'h00;
      tick();
      chk_all("rr_idle", 1'b0, 3'd0, 8'h00, 1'b0);

      // Pointer wrap: idx 7, then idx 0, then idx 7 again from ptr 1.
      req = 8'b0000_0001;
      tick();
      chk_all("wrap_g7", 1'b1, 3'd7, 8'b0000_0001, 1'b0);     // ptr -> 0
      req = 8'b1000_0001;
      rel = 1'b1;
      tick();
      chk_all("wrap_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;
      tick();
      chk_all("wrap_g0", 1'b1, 3'd0, 8'b1000_0000, 1'b0);     // ptr -> 1
      rel = 1'b1;
      tick();
      rel = 1'b0;
      tick();
      chk_all("wrap_ptr1", 1'b1, 3'd7, 8'b0000_0001, 1'b0);   // ptr -> 0
      rel = 1'b1;
      tick();
      chk_all("wrap_gap2", 1'b0, 3'd0, 8'h00, 1'b0);

      // Timeout: lone requester 0 holds with no release.
      req = 8'b1000_0000;
      rel = 1'b0;
      tick();
      chk_all("to_c1", 1'b1, 3'd0, 8'b1000_0000, 1'b0);
      tick();
      chk_all("to_c2", 1'b1, 3'd0, 8'b1000_0000, 1'b0);
      tick();
      chk_all("to_c3", 1'b1, 3'd0, 8'b1000_0000, 1'b0);
      tick();
      chk_all("to_c4", 1'b1, 3'd0, 8'b1000_0000, 1'b0);
      tick();
      chk_all("to_pulse", 1'b0, 3'd0, 8'h00, 1'b1);
      tick();
      chk_all("to_regrant", 1'b1, 3'd0, 8'b1000_0000, 1'b0);  // ptr -> 1

      // Release in the 4th grant cycle wins over the timeout.
      tick();
      tick();
      tick();
      chk_all("col_c4", 1'b1, 3'd0, 8'b1000_0000, 1'b0);
      rel = 1'b1;
      tick();
      chk_all("col_release", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;
      tick();
      chk_all("col_regrant", 1'b1, 3'd0, 8'b1000_0000, 1'b0); // ptr -> 1

      // Request drop ends the grant without a timeout.
      req = 8'h00;
      tick();
      chk_all("drop0", 1'b0, 3'd0, 8'h00, 1'b0);
      req = 8'b0001_0000;
      tick();
      chk_all("drop_g3", 1'b1, 3'd3, 8'b0001_0000, 1'b0);     // ptr -> 4
      req = 8'h00;
      tick();
      chk_all("drop_end", 1'b0, 3'd0, 8'h00, 1'b0);

      // Release while idle has no effect.
      rel = 1'b1;
      tick();
      chk_all("idle_release", 1'b0, 3'd0, 8'h00, 1'b0);
      rel = 1'b0;

      // Asynchronous reset in the middle of a grant.
      req = 8'b1000_0000;
      tick();
      chk_all("pre_rst_grant", 1'b1, 3'd0, 8'b1000_0000, 1'b0); // search 4..7,0
      #2;
      rst = 1'b1;
      req = 8'h00;
      #1;
      chk_all("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_all("post_rst", 1'b0, 3'd0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffs_rr_arbiter.md
Name: ffs_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N_CANDIDATES requesters.
- The winner is picked with the team's first-set-search convention: index 0 is the MSB of the request vector.
- A search pointer rotates after every grant, so the MSB does not starve lower bits.
- A grant is held until the owner releases it, drops its request, or a hold timeout forces release.

Parameters:
- N_CANDIDATES, 8, number of requesters; power of 2, at least 2; checked at elaboration with $fatal.
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay valid; at least 1.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req  input  N_CANDIDATES  request vector; requester index k drives bit N_CANDIDATES-1-k.
- i_release  input  1  current owner finished; sampled only in GRANT.
- o_grant_valid  output  1  grant active.
- o_grant_idx  output  $clog2(N_CANDIDATES)  granted index, MSB-first numbering.
- o_grant_onehot  output  N_CANDIDATES  one-hot grant in the same bit positions as i_req; all zeros when o_grant_valid=0.
- o_timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, pointer=0, hold counter=0.
  - o_grant_valid=0, o_grant_idx=0, o_grant_onehot=0, o_timeout=0.
  - Reset mid-grant drops the grant immediately; no timeout pulse.
- All outputs are registered.
- Search:
  - Combinational, over i_req in index order pointer, pointer+1, …, N_CANDIDATES-1, 0, …, pointer-1.
  - Index arithmetic is modulo N_CANDIDATES using natural wrap at $clog2(N_CANDIDATES) bits.
  - Result is the first index whose bit is set, plus an any-request flag.
- IDLE state:
  - If any i_req bit is set at an edge: go to GRANT at that edge.
  - At the same edge: o_grant_valid=1, o_grant_idx=winner, o_grant_onehot=winner bit, pointer=winner+1 (mod N), hold counter=1.
  - Latency is 1 cycle from request sampled to grant visible.
  - If no request: stay in IDLE, all grant outputs 0.
- GRANT state, evaluated each edge in this priority order:
  - a) i_release=1, or the owner's i_req bit=0: go to IDLE, grant outputs cleared, no timeout.
  - b) Otherwise, if hold counter == MAX_HOLD: go to IDLE, grant outputs cleared, o_timeout=1 for exactly this one cycle.
  - c) Otherwise: hold counter+1, outputs unchanged.
- Consequences of the GRANT rules:
  - o_grant_valid is high for at most MAX_HOLD consecutive cycles.
  - Release and timeout in the same cycle counts as a release; o_timeout stays 0.
  - Back-to-back grants are always separated by exactly one cycle with o_grant_valid=0, spent in IDLE.
  - No re-arbitration happens inside GRANT; new requests wait.
- Pointer:
  - Changes only when a grant is issued.
  - Wraps from N_CANDIDATES-1 to 0.
  - A timed-out requester still requesting is searched last on the next round when other requesters are pending.
- i_release outside GRANT is ignored.
- i_req is not required to be stable except for the owner's own bit.
- o_grant_onehot always equals the decode of o_grant_idx gated by o_grant_valid.

Test Plan:
- Reset test: assert i_rst with i_req=8'hFF, release it mid-cycle → all outputs 0 during reset. First edge after deassert gives o_grant_idx=0, o_grant_onehot=8'b1000_0000.
- Round-robin test:
  - i_req=8'b0010_0100 held; pulse i_release one cycle after each grant.
  - Grants alternate idx 2 (onehot 8'b0010_0000) and idx 5 (onehot 8'b0000_0100).
  - Each pair of grants is separated by one cycle with o_grant_valid=0.
- Pointer-wrap test: grant idx 7 (i_req=8'b0000_0001), then i_req=8'b1000_0001 → next grant is idx 0, pointer wraps to 1.
- Timeout test: MAX_HOLD=4, i_req=8'b1000_0000 held, no release.
  - o_grant_valid high 4 cycles.
  - o_timeout=1 in the cycle after, with o_grant_valid=0.
  - Regrant idx 0 one cycle later.
- Release/timeout collision test: MAX_HOLD=4, i_release asserted in the 4th grant cycle → release; o_timeout stays 0.
- Request-drop test: grant idx 3 (i_req=8'b0001_0000), deassert i_req bit 4 → o_grant_valid=0 at the next edge, o_timeout=0.
